// File: rtl/rou_msg_arb.sv
// rou_msg_arb
//   Round-robin arbiter and tag allocator in front of the roubus message
//   builder. NREQ requesters share one registered valid/ready message port.
//   Each accepted request is assigned the lowest free tag from a 2**TWID pool,
//   and the tag goes back into the pool when the responder retires it.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   req_vld        per-requester request valid
//   req_data/addr/bytes/cmd  requester fields, requester i at [i*W +: W]
//   req_ack        one-hot accept pulse (combinational, same cycle as load)
//   req_tag        tag given to the acked requester
//   msg_vld/msg    registered output message {data,addr,bytes,tag,cmd}
//   msg_rdy        downstream ready
//   tag_ret_vld/tag_ret  tag retire strobe and index
//   tags_busy      number of allocated tags (0..NTAG)
//   err_dbl_free   one-cycle pulse after a retire of a tag that was already free
module rou_msg_arb #(
    parameter int NREQ = 4,
    parameter int DWID = 128,
    parameter int AWID = 32,
    parameter int TWID = 5,
    parameter int BWID = (DWID == 512) ? 6 : (DWID == 256) ? 5 :
                         (DWID == 128) ? 4 : (DWID == 64) ? 3 : 2,
    parameter int WID  = 2 + DWID + AWID + BWID + TWID
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_vld,
    input  logic [NREQ*DWID-1:0]   req_data,
    input  logic [NREQ*AWID-1:0]   req_addr,
    input  logic [NREQ*BWID-1:0]   req_bytes,
    input  logic [NREQ*2-1:0]      req_cmd,
    output logic [NREQ-1:0]        req_ack,
    output logic [TWID-1:0]        req_tag,
    output logic                   msg_vld,
    input  logic                   msg_rdy,
    output logic [WID-1:0]         msg,
    input  logic                   tag_ret_vld,
    input  logic [TWID-1:0]        tag_ret,
    output logic [TWID:0]          tags_busy,
    output logic                   err_dbl_free
);

    localparam int NTAG = 2 ** TWID;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TWID:0] NTAG_C = (TWID + 1)'(NTAG);
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    logic [PW-1:0]   ptr;
    logic [NTAG-1:0] free_map;   // 1 = tag available

    logic [PW-1:0]   win;
    logic            found;
    int              idx;
    logic [TWID-1:0] tag;
    logic            load;
    logic            ret_ok;
    logic            dbl;

    logic [DWID-1:0] w_data;
    logic [AWID-1:0] w_addr;
    logic [BWID-1:0] w_bytes;
    logic [1:0]      w_cmd;

    // Rotating priority: search starts one past the last winner.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_vld[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Lowest-index free tag; scanning downward leaves the lowest one last.
    always_comb begin
        tag = '0;
        for (int t = NTAG - 1; t >= 0; t--) begin
            if (free_map[t]) tag = TWID'(t);
        end
    end

    // Winner field mux.
    always_comb begin
        w_data  = '0;
        w_addr  = '0;
        w_bytes = '0;
        w_cmd   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                w_data  = req_data[i*DWID +: DWID];
                w_addr  = req_addr[i*AWID +: AWID];
                w_bytes = req_bytes[i*BWID +: BWID];
                w_cmd   = req_cmd[i*2 +: 2];
            end
        end
    end

    // rst gating keeps the ack outputs quiet while reset is held.
    assign load = !rst && (!msg_vld || msg_rdy) && (|req_vld) && (tags_busy < NTAG_C);

    // Retire checks the registered bitmap, so a tag freed this cycle is
    // never the one allocated this cycle, and an allocated tag cannot be
    // retired in the same cycle it is handed out.
    assign dbl    = tag_ret_vld && free_map[tag_ret];
    assign ret_ok = tag_ret_vld && !free_map[tag_ret];

    always_comb begin
        req_ack = '0;
        req_tag = '0;
        if (load) begin
            req_ack[win] = 1'b1;
            req_tag      = tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_vld <= 1'b0;
            msg     <= '0;
            ptr     <= PTR_RST;
        end else if (load) begin
            msg_vld <= 1'b1;
            msg     <= {w_data, w_addr, w_bytes, tag, w_cmd};
            ptr     <= win;
        end else if (msg_rdy) begin
            msg_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_map     <= '1;
            tags_busy    <= '0;
            err_dbl_free <= 1'b0;
        end else begin
            for (int t = 0; t < NTAG; t++) begin
                if (load && tag == TWID'(t))
                    free_map[t] <= 1'b0;
                else if (ret_ok && tag_ret == TWID'(t))
                    free_map[t] <= 1'b1;
            end
            case ({load, ret_ok})
                2'b10:   tags_busy <= tags_busy + 1'b1;
                2'b01:   tags_busy <= tags_busy - 1'b1;
                default: tags_busy <= tags_busy;
            endcase
            err_dbl_free <= dbl;
        end
    end

endmodule

// File: tb/tb_rou_msg_arb.sv
module tb_rou_msg_arb;

    localparam int NREQ = 4;
    localparam int DWID = 128;
    localparam int AWID = 32;
    localparam int TWID = 5;
    localparam int BWID = 4;
    localparam int WID  = 2 + DWID + AWID + BWID + TWID;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ*DWID-1:0] req_data;
    logic [NREQ*AWID-1:0] req_addr;
    logic [NREQ*BWID-1:0] req_bytes;
    logic [NREQ*2-1:0]    req_cmd;
    logic [NREQ-1:0]      req_ack;
    logic [TWID-1:0]      req_tag;
    logic                 msg_vld;
    logic                 msg_rdy;
    logic [WID-1:0]       msg;
    logic                 tag_ret_vld;
    logic [TWID-1:0]      tag_ret;
    logic [TWID:0]        tags_busy;
    logic                 err_dbl_free;

    int checks   = 0;
    int failures = 0;

    rou_msg_arb #(.NREQ(NREQ), .DWID(DWID), .AWID(AWID), .TWID(TWID)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_data(req_data), .req_addr(req_addr),
        .req_bytes(req_bytes), .req_cmd(req_cmd),
        .req_ack(req_ack), .req_tag(req_tag),
        .msg_vld(msg_vld), .msg_rdy(msg_rdy), .msg(msg),
        .tag_ret_vld(tag_ret_vld), .tag_ret(tag_ret),
        .tags_busy(tags_busy), .err_dbl_free(err_dbl_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed per-requester field values.
    function automatic logic [DWID-1:0] f_data(int i);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(i);
        return {w, w, w, w};
    endfunction
    function automatic logic [AWID-1:0] f_addr(int i);
        return 32'h100 + 32'(i * 16);
    endfunction
    function automatic logic [BWID-1:0] f_bytes(int i);
        return BWID'(i + 1);
    endfunction
    function automatic logic [1:0] f_cmd(int i);
        return 2'(i + 2);
    endfunction
    function automatic logic [WID-1:0] exp_msg(int i, logic [TWID-1:0] t);
        return {f_data(i), f_addr(i), f_bytes(i), t, f_cmd(i)};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req_vld     = '0;
        tag_ret_vld = 1'b0;
        tag_ret     = '0;
        msg_rdy     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        req_vld     = '0;
        tag_ret_vld = 1'b0;
        tag_ret     = '0;
        msg_rdy     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DWID +: DWID]  = f_data(i);
            req_addr[i*AWID +: AWID]  = f_addr(i);
            req_bytes[i*BWID +: BWID] = f_bytes(i);
            req_cmd[i*2 +: 2]         = f_cmd(i);
        end
        tick();
        checks++;
        if ({msg_vld, req_ack, tags_busy, err_dbl_free} !== '0 || msg !== '0) begin
            failures++;
            $display("FAIL reset_state vld=%0b ack=%b busy=%0d err=%0b msg=%h, want all zero",
                     msg_vld, req_ack, tags_busy, err_dbl_free, msg);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_vld = 4'b0001;
        msg_rdy = 1'b1;
        #1;
        checks++;
        if (req_ack !== 4'b0001 || req_tag !== 5'd0) begin
            failures++;
            $display("FAIL single_ack ack=%b tag=%0d, want 0001 tag 0", req_ack, req_tag);
        end
        tick();
        req_vld = '0;
        #1;
        checks++;
        if (msg_vld !== 1'b1 || msg !== exp_msg(0, 5'd0)) begin
            failures++;
            $display("FAIL single_msg vld=%0b msg=%h, want 1 %h", msg_vld, msg, exp_msg(0, 5'd0));
        end
        checks++;
        if (msg[1:0] !== 2'd2 || msg[TWID+1:2] !== 5'd0 || msg[TWID+BWID+2 +: AWID] !== 32'h100) begin
            failures++;
            $display("FAIL single_fields cmd=%0d tag=%0d addr=%h, want 2 0 100",
                     msg[1:0], msg[TWID+1:2], msg[TWID+BWID+2 +: AWID]);
        end
        checks++;
        if (tags_busy !== 6'd1) begin
            failures++;
            $display("FAIL single_busy got %0d want 1", tags_busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_vld = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (req_ack !== 4'(1 << (i % 4)) || req_tag !== 5'(i)) begin
                failures++;
                $display("FAIL rr_grant%0d ack=%b tag=%0d, want %b tag %0d",
                         i, req_ack, req_tag, 4'(1 << (i % 4)), i);
            end
            tick();
        end
        req_vld = '0;
        #1;
        checks++;
        if (tags_busy !== 6'd8 || msg !== exp_msg(3, 5'd7)) begin
            failures++;
            $display("FAIL rr_final busy=%0d msg=%h, want 8 %h", tags_busy, msg, exp_msg(3, 5'd7));
        end
    endtask

    task automatic test_backpressure();
        logic [WID-1:0] m0;
        do_reset();
        msg_rdy = 1'b0;
        req_vld = 4'b0011;
        #1;
        checks++;
        if (req_ack !== 4'b0001 || req_tag !== 5'd0) begin
            failures++;
            $display("FAIL bp_first ack=%b tag=%0d, want 0001 tag 0", req_ack, req_tag);
        end
        tick();
        req_vld = 4'b0010;
        m0 = exp_msg(0, 5'd0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ack !== 4'b0000 || msg_vld !== 1'b1 || msg !== m0) begin
                failures++;
                $display("FAIL bp_hold%0d ack=%b vld=%0b msg=%h, want 0000 1 %h",
                         c, req_ack, msg_vld, msg, m0);
            end
            tick();
        end
        msg_rdy = 1'b1;
        #1;
        checks++;
        if (req_ack !== 4'b0010 || req_tag !== 5'd1) begin
            failures++;
            $display("FAIL bp_release ack=%b tag=%0d, want 0010 tag 1", req_ack, req_tag);
        end
        tick();
        req_vld = '0;
        #1;
        checks++;
        if (msg_vld !== 1'b1 || msg !== exp_msg(1, 5'd1)) begin
            failures++;
            $display("FAIL bp_second_msg vld=%0b msg=%h, want 1 %h", msg_vld, msg, exp_msg(1, 5'd1));
        end
    endtask

    task automatic test_exhaust();
        do_reset();
        req_vld = 4'b0001;
        for (int i = 0; i < 32; i++) begin
            #1;
            checks++;
            if (req_ack !== 4'b0001 || req_tag !== 5'(i)) begin
                failures++;
                $display("FAIL exh_alloc%0d ack=%b tag=%0d, want 0001 tag %0d", i, req_ack, req_tag, i);
            end
            tick();
        end
        #1;
        checks++;
        if (tags_busy !== 6'd32 || req_ack !== 4'b0000) begin
            failures++;
            $display("FAIL exh_full busy=%0d ack=%b, want 32 0000", tags_busy, req_ack);
        end
        tag_ret_vld = 1'b1;
        tag_ret     = 5'd7;
        #1;
        checks++;
        if (req_ack !== 4'b0000) begin
            failures++;
            $display("FAIL exh_ret_cycle ack=%b, want 0000", req_ack);
        end
        tick();
        tag_ret_vld = 1'b0;
        #1;
        checks++;
        if (req_ack !== 4'b0001 || req_tag !== 5'd7 || tags_busy !== 6'd31 || msg_vld !== 1'b0) begin
            failures++;
            $display("FAIL exh_realloc ack=%b tag=%0d busy=%0d vld=%0b, want 0001 7 31 0",
                     req_ack, req_tag, tags_busy, msg_vld);
        end
        tick();
        req_vld = '0;
        #1;
        checks++;
        if (tags_busy !== 6'd32 || msg !== exp_msg(0, 5'd7)) begin
            failures++;
            $display("FAIL exh_after busy=%0d msg=%h, want 32 %h", tags_busy, msg, exp_msg(0, 5'd7));
        end
    endtask

    task automatic test_retire();
        do_reset();
        tag_ret_vld = 1'b1;
        tag_ret     = 5'd3;
        tick();
        tag_ret_vld = 1'b0;
        #1;
        checks++;
        if (err_dbl_free !== 1'b1 || tags_busy !== 6'd0) begin
            failures++;
            $display("FAIL dbl_free err=%0b busy=%0d, want 1 0", err_dbl_free, tags_busy);
        end
        tick();
        checks++;
        if (err_dbl_free !== 1'b0) begin
            failures++;
            $display("FAIL dbl_free_pulse err=%0b, want 0", err_dbl_free);
        end
        req_vld = 4'b0001;
        tick();
        tick();
        tag_ret_vld = 1'b1;
        tag_ret     = 5'd0;
        #1;
        checks++;
        if (req_ack !== 4'b0001 || req_tag !== 5'd2 || tags_busy !== 6'd2) begin
            failures++;
            $display("FAIL same_cycle_alloc ack=%b tag=%0d busy=%0d, want 0001 2 2",
                     req_ack, req_tag, tags_busy);
        end
        tick();
        tag_ret_vld = 1'b0;
        #1;
        checks++;
        if (tags_busy !== 6'd2 || err_dbl_free !== 1'b0 || req_tag !== 5'd0) begin
            failures++;
            $display("FAIL same_cycle_result busy=%0d err=%0b tag=%0d, want 2 0 0",
                     tags_busy, err_dbl_free, req_tag);
        end
        tick();
        req_vld = '0;
        #1;
        checks++;
        if (tags_busy !== 6'd3) begin
            failures++;
            $display("FAIL retire_final busy=%0d, want 3", tags_busy);
        end
    endtask

    task automatic test_midflight_reset();
        do_reset();
        req_vld = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        req_vld = 4'b0100;
        msg_rdy = 1'b0;
        #1;
        checks++;
        if (msg_vld !== 1'b1 || tags_busy !== 6'd10) begin
            failures++;
            $display("FAIL mid_pre vld=%0b busy=%0d, want 1 10", msg_vld, tags_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (msg_vld !== 1'b0 || tags_busy !== 6'd0 || req_ack !== 4'b0000) begin
            failures++;
            $display("FAIL mid_rst vld=%0b busy=%0d ack=%b, want 0 0 0000", msg_vld, tags_busy, req_ack);
        end
        tick();
        rst     = 1'b0;
        req_vld = 4'b0101;
        #1;
        checks++;
        if (req_ack !== 4'b0001 || req_tag !== 5'd0) begin
            failures++;
            $display("FAIL mid_post_grant ack=%b tag=%0d, want 0001 tag 0", req_ack, req_tag);
        end
        tick();
        req_vld = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_exhaust();
        test_retire();
        test_midflight_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
